// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter owning one 3-to-8 decoder: 1-cycle grant latency, one dead cycle between grants.
// DECODER_ARB_TIMEOUT_EN bounds each grant to MAX_HOLD cycles and pulses timeout on forced release.
module decoder_rr_arbiter #(
  parameter logic [2:0] PTR_INIT = 3'd0,
  parameter int         MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       sel_a,
  output logic       sel_b,
  output logic       sel_c,
  output logic       en_n,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [2:0] r_idx;
  logic       r_en_n;
  logic       r_grant_valid;
  logic       r_timeout;

  logic       w_found;
  logic [2:0] w_winner;
  logic       w_release;
  logic       w_force;

  // Scan offsets high to low so the smallest offset from r_ptr wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    for (int k = 7; k >= 0; k--) begin
      if (req[r_ptr + 3'(k)]) begin
        w_found  = 1'b1;
        w_winner = r_ptr + 3'(k);
      end
    end
  end

  assign w_release = done | ~req[r_idx];

`ifdef DECODER_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] r_hold_cnt;

  assign w_force = (r_hold_cnt == HW'(MAX_HOLD - 1)) & ~w_release;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != '1) begin
      r_hold_cnt <= r_hold_cnt + HW'(1);
    end
  end
`else
  assign w_force = (MAX_HOLD < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= PTR_INIT;
      r_idx         <= 3'd0;
      r_en_n        <= 1'b1;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state       <= GRANT;
            r_idx         <= w_winner;
            r_en_n        <= 1'b0;
            r_grant_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (w_release || w_force) begin
            r_state       <= IDLE;
            r_ptr         <= r_idx + 3'd1;
            r_en_n        <= 1'b1;
            r_grant_valid <= 1'b0;
            r_timeout     <= w_force;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sel_a       = r_idx[0];
  assign sel_b       = r_idx[1];
  assign sel_c       = r_idx[2];
  assign grant_idx   = r_idx;
  assign en_n        = r_en_n;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter; timeout section follows DECODER_ARB_TIMEOUT_EN.
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       sel_a, sel_b, sel_c, en_n, grant_valid, timeout;
  logic [2:0] grant_idx;

  int total = 0;
  int bad   = 0;

  decoder_rr_arbiter #(.PTR_INIT(3'd0), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .en_n(en_n),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant held: enable low, valid high, decoder selects and index agree.
  task automatic chk_grant(input string tag, input logic [2:0] idx);
    chk({tag, ".en_n"}, {7'd0, en_n}, 8'd0);
    chk({tag, ".gv"}, {7'd0, grant_valid}, 8'd1);
    chk({tag, ".idx"}, {5'd0, grant_idx}, {5'd0, idx});
    chk({tag, ".sel"}, {5'd0, sel_c, sel_b, sel_a}, {5'd0, idx});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".en_n"}, {7'd0, en_n}, 8'd1);
    chk({tag, ".gv"}, {7'd0, grant_valid}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b1; req = 8'h00; done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_idle("rst0");
    chk("rst0.idx", {5'd0, grant_idx}, 8'd0);
    chk("rst0.to", {7'd0, timeout}, 8'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk_idle("idle_noreq");

    // Single request from ptr=0
    req = 8'h20;
    tick();
    chk_grant("single", 3'd5);
    done = 1'b1;
    tick();
    chk_idle("single_rel");
    chk("single_rel.idx", {5'd0, grant_idx}, 8'd5);
    done = 1'b0; req = 8'h00;
    tick();

    // ptr=6, req=05: expect 0, 2, 0
    req = 8'h05;
    tick();
    chk_grant("wrap0", 3'd0);
    done = 1'b1; tick(); chk_idle("wrap0_rel");
    done = 1'b0; tick();
    chk_grant("wrap2", 3'd2);
    done = 1'b1; tick(); chk_idle("wrap2_rel");
    done = 1'b0; tick();
    chk_grant("wrap0b", 3'd0);
    done = 1'b1; tick();
    done = 1'b0; req = 8'h00;
    tick();

    // ptr=1: grant 1, then reset mid-grant
    req = 8'hFF;
    tick();
    chk_grant("pre_rst", 3'd1);
    rst_n = 1'b0; req = 8'h00;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid.sel", {5'd0, sel_c, sel_b, sel_a}, 8'd0);
    chk("rst_mid.idx", {5'd0, grant_idx}, 8'd0);
    chk("rst_mid.to", {7'd0, timeout}, 8'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk_idle("post_rst_noreq");

    // Round robin from restored ptr=0 with done held high
    req = 8'hFF; done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_grant($sformatf("rr%0d", i), 3'(i % 8));
      tick();
      chk_idle($sformatf("rr%0d_dead", i));
    end
    req = 8'h00; done = 1'b0;
    tick();

    // Request drop: ptr=1, req=08 -> grant 3, drop -> ptr 4
    req = 8'h08;
    tick();
    chk_grant("drop3", 3'd3);
    req = 8'h00;
    tick();
    chk_idle("drop3_rel");
    req = 8'h11;
    tick();
    chk_grant("drop_ptr4", 3'd4);
    req = 8'h00; done = 1'b1;
    tick();
    chk_idle("both_rel");
    done = 1'b0; req = 8'h21;
    tick();
    chk_grant("both_ptr5", 3'd5);
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h00;
    tick();

    // Timeout: ptr=6, req[1] held, done low
    req = 8'h02;
    tick();
    chk_grant("hold_c1", 3'd1);
`ifdef DECODER_ARB_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk_grant($sformatf("hold_c%0d", c), 3'd1);
      chk($sformatf("hold_c%0d.to", c), {7'd0, timeout}, 8'd0);
    end
    tick();
    chk_idle("to_rel");
    chk("to_pulse", {7'd0, timeout}, 8'd1);
    tick();
    chk_grant("to_regrant", 3'd1);
    chk("to_regrant.to", {7'd0, timeout}, 8'd0);
`else
    for (int c = 2; c <= 20; c++) begin
      tick();
      chk_grant($sformatf("hold_c%0d", c), 3'd1);
      chk($sformatf("hold_c%0d.to", c), {7'd0, timeout}, 8'd0);
    end
`endif
    done = 1'b1;
    tick();
    chk_idle("final_rel");
    done = 1'b0; req = 8'h00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
Round-robin arbiter that shares one 3-to-8 decoder among 8 requesters. It drives the decoder's select lines (a, b, c) and its active-low enable, so exactly one decoder output is active for the duration of each grant. It holds each grant until the owner signals done or withdraws its request. It enforces a break-before-make dead cycle between consecutive grants.

Parameters:
PTR_INIT, 0, initial round-robin pointer after reset (0..7)
MAX_HOLD, 16, maximum grant length in cycles when the timeout feature is compiled in (>=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  8  request vector; bit i = requester i
done  input  1  owner's release pulse; sampled only in GRANT
sel_a  output  1  decoder select bit 0 (LSB)
sel_b  output  1  decoder select bit 1
sel_c  output  1  decoder select bit 2 (MSB)
en_n  output  1  decoder enable, active-low; 0 only in GRANT
grant_valid  output  1  high while a grant is held (equals ~en_n)
grant_idx  output  3  index of current or last grantee, {sel_c,sel_b,sel_a}
timeout  output  1  one-cycle pulse on forced release; constant 0 without the macro

Behaviour:
- Reset (async assert, sync release on clk):
  - State = IDLE; en_n=1; grant_valid=0.
  - sel_a=sel_b=sel_c=0; grant_idx=0; timeout=0.
  - ptr=PTR_INIT; hold_cnt=0.
- All outputs are registered. No combinational path from req or done to any output.
- State IDLE:
  - en_n=1.
  - If req!=0, the winner is the first set bit searched from ptr upward with mod-8 wrap: ptr, ptr+1, ..., ptr+7.
  - At the next edge: state=GRANT, grant_idx=winner, en_n=0, grant_valid=1.
  - Latency: 1 cycle from req sampled in IDLE to en_n low.
  - If req==0, stay in IDLE; sel retains the last value.
  - done is ignored in IDLE.
- State GRANT:
  - en_n=0; sel is stable for the whole grant.
  - Release condition: done==1 OR req[grant_idx]==0 (OR timeout, when compiled in).
  - On release, at the next edge:
    - state=IDLE, en_n=1, grant_valid=0.
    - ptr = grant_idx+1 (3-bit wrap, so 7 -> 0).
    - sel/grant_idx hold their value.
  - Other requesters cannot preempt.
- Dead cycle: at least one IDLE cycle (en_n=1) separates consecutive grants. Back-to-back grants therefore have a period of grant_length+1 cycles.
- Simultaneous done and drop of req[grant_idx]: a single release; ptr advances once.
- Requests arriving during GRANT are evaluated in the following IDLE cycle against the updated ptr.
- Fairness: with req=8'hFF held, grants are issued in the order ptr, ptr+1, ... cyclically. No requester waits more than 7 grants.
- Reset during GRANT: en_n goes high immediately (async) and all state returns to reset values. ptr returns to PTR_INIT.
- hold_cnt: cleared on entry to GRANT; increments each GRANT cycle; saturates.

Optional Feature:
DECODER_ARB_TIMEOUT_EN
- Defined:
  - In GRANT, when hold_cnt==MAX_HOLD-1 and no other release condition is true, a forced release occurs.
  - timeout pulses 1 for exactly one cycle, coincident with the transition to IDLE.
  - ptr advances as for a normal release.
  - Grant length is therefore never more than MAX_HOLD cycles.
- Undefined:
  - Grants are unbounded; timeout is tied 0; the hold_cnt logic is removed.

Test Plan:
- Reset check: assert rst_n=0 mid-run -> en_n=1, grant_valid=0, sel=000, grant_idx=0, timeout=0 immediately. After release, no grant while req=0.
- Single request: ptr=0, req=8'h20 -> one cycle later en_n=0, {c,b,a}=101, grant_idx=5. Pulse done -> en_n=1 next cycle. Next grant search starts at 6.
- Round-robin: req=8'hFF held, done pulsed in every GRANT cycle -> grant_idx sequence 0,1,2,...,7,0. Exactly one en_n=1 cycle between consecutive grants.
- Wrap and skip: ptr=6, req=8'h05 -> grant 0, then 2, then 0. Never 6 or 7.
- Request drop: grant 3, deassert req[3] with done=0 -> release next edge; ptr=4. Simultaneous done and req drop -> single release.
- Timeout (macro on, MAX_HOLD=4): req[1] held, done=0 -> en_n low for exactly 4 cycles; timeout=1 for one cycle; re-grant to 1 only after the IDLE cycle when no other requester is pending. Macro off: same stimulus holds the grant indefinitely with timeout=0.
